// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state codes,
// bus-select codes and the bit layout of the registered control word.
package ctrl_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDMAR = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_LOOP  = 4'hB;
  localparam logic [3:0] OP_MOV   = 4'hC;
  localparam logic [3:0] OP_TX    = 4'hD;
  localparam logic [3:0] OP_RX    = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DECODE   = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_WAIT_MEM = 3'd3;
  localparam logic [2:0] ST_WAIT_TX  = 3'd4;
  localparam logic [2:0] ST_WAIT_RX  = 3'd5;
  localparam logic [2:0] ST_HALT     = 3'd6;

  localparam int BUS_SEL_UART_RX = 4;

  localparam logic [4:0] MOV_DST_MEM_A = 5'b00001;
  localparam logic [4:0] MOV_DST_MEM_B = 5'b00010;
  localparam logic [4:0] MOV_DST_LR    = 5'b00011;
  localparam logic [4:0] MOV_DST_AC    = 5'b00101;
  localparam logic [4:0] MOV_DST_GPR   = 5'b00110;

  // Control word layout: datapath fields, strobes, then sequencing hints.
  localparam int CW_AC       = 0;
  localparam int CW_ALU      = 2;
  localparam int CW_MEM      = 5;
  localparam int CW_GPR_WE   = 8;
  localparam int CW_LR_WE    = 9;
  localparam int CW_LR_DEC   = 10;
  localparam int CW_TX_WE    = 11;
  localparam int CW_RX_CLR   = 12;
  localparam int CW_DRAM_WE  = 13;
  localparam int CW_PC_INC   = 14;
  localparam int CW_PC_JMP   = 15;
  localparam int CW_BR_Z     = 16;
  localparam int CW_BR_LRZ   = 17;
  localparam int CW_WAIT_MEM = 18;
  localparam int CW_WAIT_TX  = 19;
  localparam int CW_WAIT_RX  = 20;
  localparam int CW_HALT     = 21;
  localparam int CW_ILLEGAL  = 22;
  localparam int CW_W        = 23;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ctrl_seq_lut.sv
// Combinational opcode/destination decoder producing one control word.
// Optional feature macro: CTRL_SEQ_ILLEGAL_TRAP_EN (undefined MOV dest traps).
module ctrl_seq_lut
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int GPR_AW    = 4,
  parameter int BUS_SEL_W = 5
) (
  input  logic [INSTR_W-1:0]   i_instr,
  output ctrl_word_t           o_cw,
  output logic [BUS_SEL_W-1:0] o_bus_sel,
  output logic [GPR_AW-1:0]    o_gpr_addr_out
);

  logic [3:0] w_op;
  logic [4:0] w_dst;
  logic       w_unused_instr;

  assign w_op           = i_instr[INSTR_W-1 -: 4];
  assign w_dst          = i_instr[4:0];
  assign w_unused_instr = i_instr[5];

  always_comb begin
    o_cw           = '0;
    o_bus_sel      = i_instr[7 +: BUS_SEL_W];
    o_gpr_addr_out = i_instr[7 +: GPR_AW];
    case (w_op)
      OP_NOP: o_cw[CW_PC_INC] = 1'b1;
      OP_LDMAR: begin
        o_cw[CW_MEM +: 3] = 3'b011;
        o_cw[CW_PC_INC]   = 1'b1;
      end
      OP_STORE: begin
        o_cw[CW_DRAM_WE]  = 1'b1;
        o_cw[CW_PC_INC]   = 1'b1;
        o_cw[CW_WAIT_MEM] = 1'b1;
      end
      OP_JMP:  o_cw[CW_PC_JMP] = 1'b1;
      OP_JZ:   o_cw[CW_BR_Z]   = 1'b1;
      OP_LOOP: begin
        o_cw[CW_BR_LRZ] = 1'b1;
        o_cw[CW_LR_DEC] = 1'b1;
      end
      OP_MOV: begin
        // MOV carries its bus source one bit lower to make room for the 5-bit dest
        o_bus_sel       = i_instr[6 +: BUS_SEL_W];
        o_gpr_addr_out  = i_instr[6 +: GPR_AW];
        o_cw[CW_PC_INC] = 1'b1;
        if (w_dst[4]) begin
          o_cw[CW_GPR_WE] = 1'b1;
        end else begin
          case (w_dst)
            MOV_DST_MEM_A: o_cw[CW_MEM +: 3] = 3'b100;
            MOV_DST_MEM_B: o_cw[CW_MEM +: 3] = 3'b010;
            MOV_DST_LR:    o_cw[CW_LR_WE]    = 1'b1;
            MOV_DST_AC:    o_cw[CW_AC +: 2]  = 2'b10;
            MOV_DST_GPR:   o_cw[CW_GPR_WE]   = 1'b1;
            default: begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
              o_cw              = '0;
              o_cw[CW_ILLEGAL]  = 1'b1;
`endif
            end
          endcase
        end
      end
      OP_TX: begin
        o_cw[CW_TX_WE]   = 1'b1;
        o_cw[CW_PC_INC]  = 1'b1;
        o_cw[CW_WAIT_TX] = 1'b1;
      end
      OP_RX: begin
        o_bus_sel        = BUS_SEL_W'(BUS_SEL_UART_RX);
        o_cw[CW_GPR_WE]  = 1'b1;
        o_cw[CW_RX_CLR]  = 1'b1;
        o_cw[CW_PC_INC]  = 1'b1;
        o_cw[CW_WAIT_RX] = 1'b1;
      end
      OP_HALT: o_cw[CW_HALT] = 1'b1;
      default: begin
        // opcodes 1..6: ALU operations
        o_cw[CW_AC +: 2]  = 2'b11;
        o_cw[CW_ALU +: 3] = w_op[2:0] - 3'd1;
        o_cw[CW_PC_INC]   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered multi-cycle control sequencer: IDLE -> DECODE -> EXEC (+ wait states).
// Optional feature macro: CTRL_SEQ_ILLEGAL_TRAP_EN (sticky illegal flag + HALT).
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int GPR_AW    = 4,
  parameter int BUS_SEL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 z_flag,
  input  logic                 lrz_flag,
  input  logic                 tx_busy,
  input  logic                 rx_ready,
  input  logic                 dram_ack,
  output logic [BUS_SEL_W-1:0] bus_sel,
  output logic [GPR_AW-1:0]    gpr_addr_out,
  output logic [GPR_AW-1:0]    gpr_addr_in,
  output logic [ADDR_W-1:0]    jmp_addr,
  output logic [1:0]           ac_ctrl,
  output logic [2:0]           alu_ctrl,
  output logic [2:0]           mem_ctrl,
  output logic                 gpr_we,
  output logic                 lr_we,
  output logic                 lr_dec,
  output logic                 pc_inc,
  output logic                 pc_jmp,
  output logic                 uart_tx_we,
  output logic                 uart_rx_clr,
  output logic                 dram_we,
  output logic                 halted,
  output logic                 illegal
);

  if (ADDR_W > INSTR_W - 4 || DATA_W < 1) begin : g_param_check
    $error("ctrl_sequencer: ADDR_W must fit below the opcode field");
  end

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [INSTR_W-1:0]   r_instr;
  ctrl_word_t           r_cw;
  ctrl_word_t           w_lut_cw;
  logic [BUS_SEL_W-1:0] r_bus_sel;
  logic [BUS_SEL_W-1:0] w_lut_bus_sel;
  logic [GPR_AW-1:0]    r_gpr_out;
  logic [GPR_AW-1:0]    w_lut_gpr_out;
  logic [GPR_AW-1:0]    r_gpr_in;
  logic [ADDR_W-1:0]    r_jmp_addr;
  logic                 r_instr_ready;
  logic                 w_active;
  logic                 w_done;
  logic                 w_fire;

  ctrl_seq_lut #(
    .INSTR_W   (INSTR_W),
    .GPR_AW    (GPR_AW),
    .BUS_SEL_W (BUS_SEL_W)
  ) u_lut (
    .i_instr        (r_instr),
    .o_cw           (w_lut_cw),
    .o_bus_sel      (w_lut_bus_sel),
    .o_gpr_addr_out (w_lut_gpr_out)
  );

  // Release condition of the current instruction; plain ops complete immediately.
  always_comb begin
    w_done = 1'b1;
    if (r_cw[CW_WAIT_MEM])     w_done = dram_ack;
    else if (r_cw[CW_WAIT_TX]) w_done = !tx_busy;
    else if (r_cw[CW_WAIT_RX]) w_done = rx_ready;
  end

  assign w_active = (r_state == ST_EXEC) || (r_state == ST_WAIT_MEM) ||
                    (r_state == ST_WAIT_TX) || (r_state == ST_WAIT_RX);
  assign w_fire   = w_active && w_done;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (instr_valid) w_state_next = ST_DECODE;
      ST_DECODE: w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (r_cw[CW_HALT] || r_cw[CW_ILLEGAL]) w_state_next = ST_HALT;
        else if (w_done)                       w_state_next = ST_IDLE;
        else if (r_cw[CW_WAIT_MEM])            w_state_next = ST_WAIT_MEM;
        else if (r_cw[CW_WAIT_TX])             w_state_next = ST_WAIT_TX;
        else                                   w_state_next = ST_WAIT_RX;
      end
      ST_WAIT_MEM, ST_WAIT_TX, ST_WAIT_RX: if (w_done) w_state_next = ST_IDLE;
      ST_HALT:   w_state_next = ST_HALT;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_instr       <= '0;
      r_cw          <= '0;
      r_bus_sel     <= '0;
      r_gpr_out     <= '0;
      r_gpr_in      <= '0;
      r_jmp_addr    <= '0;
      r_instr_ready <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      // ready is registered so it stays low while reset is asserted
      r_instr_ready <= (w_state_next == ST_IDLE);
      if (r_state == ST_IDLE && instr_valid) r_instr <= instr;
      if (r_state == ST_DECODE) begin
        r_cw       <= w_lut_cw;
        r_bus_sel  <= w_lut_bus_sel;
        r_gpr_out  <= w_lut_gpr_out;
        r_gpr_in   <= r_instr[GPR_AW-1:0];
        r_jmp_addr <= r_instr[ADDR_W-1:0];
      end
    end
  end

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_illegal <= 1'b0;
    else if (r_state == ST_EXEC && r_cw[CW_ILLEGAL]) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign instr_ready  = r_instr_ready;
  assign halted       = (r_state == ST_HALT);
  assign bus_sel      = r_bus_sel;
  assign gpr_addr_out = r_gpr_out;
  assign gpr_addr_in  = r_gpr_in;
  assign jmp_addr     = r_jmp_addr;

  assign ac_ctrl     = w_fire ? r_cw[CW_AC +: 2]  : 2'b00;
  assign alu_ctrl    = w_fire ? r_cw[CW_ALU +: 3] : 3'b000;
  assign mem_ctrl    = w_fire ? r_cw[CW_MEM +: 3] : 3'b000;
  assign gpr_we      = w_fire && r_cw[CW_GPR_WE];
  assign lr_we       = w_fire && r_cw[CW_LR_WE];
  assign lr_dec      = w_fire && r_cw[CW_LR_DEC];
  assign uart_tx_we  = w_fire && r_cw[CW_TX_WE];
  assign uart_rx_clr = w_fire && r_cw[CW_RX_CLR];
  // dram_we is a level for the whole EXEC/WAIT_MEM span, unlike the strobes
  assign dram_we     = w_active && r_cw[CW_DRAM_WE];
  assign pc_inc      = w_fire && (r_cw[CW_PC_INC] ||
                                  (r_cw[CW_BR_Z] && !z_flag) ||
                                  (r_cw[CW_BR_LRZ] && lrz_flag));
  assign pc_jmp      = w_fire && (r_cw[CW_PC_JMP] ||
                                  (r_cw[CW_BR_Z] && z_flag) ||
                                  (r_cw[CW_BR_LRZ] && !lrz_flag));

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised, registered multi-cycle control unit for the image-downsampling processor; successor to the purely combinational opcode decoder.
- Accepts one instruction per valid/ready handshake, decodes it into a registered control word, and steps DECODE -> EXEC.
- Stalls in dedicated wait states on DRAM writes and UART tx/rx, replacing the old combinational pc_no_inc stall.
- Sits between instruction fetch (PC/IR) and the datapath (AC, ALU, GPR bank, LR, MAR/MBR/MDR, UART).

Parameters:
- INSTR_W, 16, instruction width; opcode is always the top 4 bits.
- DATA_W, 16, datapath word width (informational; sets no port widths here).
- ADDR_W, 12, jump/MAR address field width; must be <= INSTR_W-4.
- GPR_AW, 4, GPR bank address width.
- BUS_SEL_W, 5, main-bus mux select width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  INSTR_W  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  sequencer can accept an instruction (high only in IDLE)
- z_flag  in  1  AC zero flag
- lrz_flag  in  1  loop-register zero flag
- tx_busy  in  1  UART transmitter busy
- rx_ready  in  1  UART receive data available
- dram_ack  in  1  DRAM write complete
- bus_sel  out  BUS_SEL_W  main-bus source select
- gpr_addr_out  out  GPR_AW  GPR read address
- gpr_addr_in  out  GPR_AW  GPR write address (instr[GPR_AW-1:0])
- jmp_addr  out  ADDR_W  instr[ADDR_W-1:0], registered
- ac_ctrl  out  2  accumulator control
- alu_ctrl  out  3  ALU operation
- mem_ctrl  out  3  MAR/MBR/MDR load control
- gpr_we, lr_we, lr_dec  out  1 each  one-cycle strobes
- pc_inc, pc_jmp  out  1 each  one-cycle strobes; mutually exclusive
- uart_tx_we, uart_rx_clr  out  1 each  one-cycle strobes
- dram_we  out  1  level; held until dram_ack
- halted  out  1  HALT state reached
- illegal  out  1  sticky illegal-opcode flag (only with the optional feature)

Behaviour:
- Reset: all outputs 0; state IDLE. A reset mid-operation aborts the operation, drops pending strobes, and deasserts dram_we immediately.
- States:
  - IDLE: instr_ready=1; on instr_valid, latch instr and go to DECODE.
  - DECODE: look up the control word and register it; go to EXEC.
  - EXEC: drive registered control for exactly one cycle, then return to IDLE, except where noted below.
  - WAIT_MEM, WAIT_TX, WAIT_RX: stall states, detailed below.
  - HALT: absorbing; leaves only on reset.
- Latency: accept at cycle 0; DECODE at cycle 1; EXEC strobes and pc_inc/pc_jmp at cycle 2; instr_ready high again at cycle 3.
- Opcodes:
  - 0x0 NOP: pc_inc only.
  - 0x1-0x6 ALU: ac_ctrl=2'b11, alu_ctrl=opcode-1.
  - 0x7 LDMAR: mem_ctrl=3'b011.
  - 0x8 STORE: EXEC -> WAIT_MEM. dram_we stays high until the cycle dram_ack=1; pc_inc pulses in that same cycle; then IDLE. If dram_ack=1 already in EXEC, complete in EXEC.
  - 0x9 JMP: pc_jmp.
  - 0xA JZ: z_flag sampled in EXEC. z=1 -> pc_jmp; z=0 -> pc_inc.
  - 0xB LOOP: lr_dec always; lrz_flag sampled in EXEC. lrz=0 -> pc_jmp; lrz=1 -> pc_inc.
  - 0xC MOV: destination selected by instr[4:0]:
    - 00001: mem_ctrl=3'b100
    - 00010: mem_ctrl=3'b010
    - 00011: lr_we
    - 00101: ac_ctrl=2'b10
    - 00110: uart_tx_we is not used; it is a GPR write, gpr_we
    - 1xxxx: gpr_we
    - any other code: NOP
    - bus_sel and gpr_addr_out come from instr[10:6] and instr[9:6].
  - 0xD TX: WAIT_TX while tx_busy=1; in the first cycle with tx_busy=0, pulse uart_tx_we and pc_inc, then IDLE.
  - 0xE RX: WAIT_RX while rx_ready=0; then bus_sel=5'b00100, gpr_we, uart_rx_clr, pc_inc for one cycle.
  - 0xF HALT: pc_inc is not pulsed; halted=1.
- Non-MOV instructions: bus_sel from instr[11:7]; gpr_addr_out from instr[10:7].
- Strobes are never asserted outside EXEC and the completing cycle of a wait state.
- Flags changing while in a wait state are ignored except for that state's release condition.

Optional Feature:
- Macro CTRL_SEQ_ILLEGAL_TRAP_EN.
- Defined: 0xC with an undefined destination code sets illegal=1 (sticky until reset) and enters HALT; no strobes are issued.
- Undefined: such instructions execute as NOP, and illegal is tied to 0.

Decomposition:
- Package ctrl_seq_pkg: opcode localparams, state encoding, bus_sel codes, control-word field offsets and width.
- Sub-module ctrl_seq_lut: purely combinational opcode+dest -> control word, instantiated once; the sequencer registers its output.

Test Plan:
- ALU op 0x3123 with valid=1 -> alu_ctrl=3'b010, ac_ctrl=2'b11 and pc_inc at cycle 2; instr_ready=1 at cycle 3.
- STORE with dram_ack delayed 4 cycles -> dram_we high 5 cycles; single pc_inc coincident with ack; no second pulse.
- JZ with z=1 -> pc_jmp, jmp_addr=instr[11:0]; repeat with z=0 -> pc_inc only; never both.
- LOOP with lrz=0 -> lr_dec+pc_jmp; with lrz=1 -> lr_dec+pc_inc.
- TX with tx_busy high 10 cycles, and rst_n pulled low in cycle 5 of a second TX -> first: uart_tx_we exactly once after busy drops; second: all outputs 0 asynchronously, IDLE.
- MOV 0xC004 -> with CTRL_SEQ_ILLEGAL_TRAP_EN: illegal=1, halted=1; without the macro: pc_inc only.
